addsub_arbiter: RTL and testbench

Round-robin scheduler that shares one external 4-bit adder/subtractor among N requesters. Each requester posts operands and an add/sub select with a level request. The block grants one requester at a time and drives the shared datapath from latched operands. It registers the sum and overflow flag, returns them with a one-cycle done pulse, and keeps a saturating count of overflow events for the board's status display.

---
 rtl/addsub_arbiter_if.sv | 25 ++
 rtl/addsub_arbiter.sv | 178 +++++++++++++++++
 tb/tb_addsub_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_arbiter_if.sv
// Requester-side bus of the shared adder/subtractor arbiter: per-requester
// operands and request levels in, one-hot grant/done and the registered result out.
interface addsub_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4
);
    logic [N-1:0]   req;
    logic [N-1:0]   sub;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W-1:0]   rsp_s;
    logic           rsp_ov;

    modport master (
        output req, sub, a, b,
        input  gnt, done, rsp_s, rsp_ov
    );

    modport slave (
        input  req, sub, a, b,
        output gnt, done, rsp_s, rsp_ov
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin scheduler sharing one external W-bit adder/subtractor among N
// requesters; registers the result and keeps a saturating overflow count.
module addsub_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    addsub_arbiter_if.slave  bus,
    input  logic             ov_clr_i,
    output logic             busy_o,
    output logic [7:0]       ov_cnt_o,
    output logic [W-1:0]     as_a_o,
    output logic [W-1:0]     as_b_o,
    output logic             as_sub_o,
    input  logic [W-1:0]     as_s_i,
    input  logic             as_ov_i
);
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    done_q, done_d;
    logic [W-1:0]    rsp_s_q, rsp_s_d;
    logic            rsp_ov_q, rsp_ov_d;
    logic [W-1:0]    as_a_q, as_a_d;
    logic [W-1:0]    as_b_q, as_b_d;
    logic            as_sub_q, as_sub_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   ov_cnt_q, ov_cnt_d;

    logic            sel_vld;
    logic [PW-1:0]   sel_idx;
    logic [PW-1:0]   scan_idx;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic            sel_sub;

    // First requester at or after the pointer, scanning cyclically
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = PW'((32'(ptr_q) + k) % N);
            if (!sel_vld && bus.req[scan_idx]) begin
                sel_vld = 1'b1;
                sel_idx = scan_idx;
            end
        end
    end

    // Operand mux for the selected requester; the grant edge latches it
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel_idx == PW'(i)) begin
                sel_a   = bus.a[i*W +: W];
                sel_b   = bus.b[i*W +: W];
                sel_sub = bus.sub[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_vld) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        rsp_s_d  = rsp_s_q;
        rsp_ov_d = rsp_ov_q;
        as_a_d   = as_a_q;
        as_b_d   = as_b_q;
        as_sub_d = as_sub_q;
        busy_d   = busy_q;
        ov_cnt_d = ov_cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    gidx_d   = sel_idx;
                    gnt_d    = N'(1) << sel_idx;
                    as_a_d   = sel_a;
                    as_b_d   = sel_b;
                    as_sub_d = sel_sub;
                    busy_d   = 1'b1;
                end
            end
            EXEC: begin
                rsp_s_d  = as_s_i;
                rsp_ov_d = as_ov_i;
                done_d   = gnt_q;
                as_a_d   = '0;
                as_b_d   = '0;
                as_sub_d = 1'b0;
                if (as_ov_i && (ov_cnt_q != '1)) ov_cnt_d = ov_cnt_q + CW'(1);
            end
            RESP: begin
                ptr_d  = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + PW'(1);
                gnt_d  = '0;
                busy_d = 1'b0;
            end
            default: begin
                gnt_d  = '0;
                busy_d = 1'b0;
            end
        endcase
        // A clear wins over a same-cycle increment
        if (ov_clr_i) ov_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            gidx_q   <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            rsp_s_q  <= '0;
            rsp_ov_q <= 1'b0;
            as_a_q   <= '0;
            as_b_q   <= '0;
            as_sub_q <= 1'b0;
            busy_q   <= 1'b0;
            ov_cnt_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rsp_s_q  <= rsp_s_d;
            rsp_ov_q <= rsp_ov_d;
            as_a_q   <= as_a_d;
            as_b_q   <= as_b_d;
            as_sub_q <= as_sub_d;
            busy_q   <= busy_d;
            ov_cnt_q <= ov_cnt_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.rsp_s  = rsp_s_q;
    assign bus.rsp_ov = rsp_ov_q;
    assign busy_o     = busy_q;
    assign ov_cnt_o   = ov_cnt_q;
    assign as_a_o     = as_a_q;
    assign as_b_o     = as_b_q;
    assign as_sub_o   = as_sub_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model using plain signed arithmetic.
module tb_addsub_arbiter;
    localparam int unsigned N = 4;
    localparam int unsigned W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ov_clr;
    logic           busy;
    logic [7:0]     ov_cnt;
    logic [W-1:0]   as_a, as_b, as_s;
    logic           as_sub, as_ov;

    addsub_arbiter_if #(.N(N), .W(W)) bus ();

    addsub_arbiter #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ov_clr_i (ov_clr),
        .busy_o   (busy),
        .ov_cnt_o (ov_cnt),
        .as_a_o   (as_a),
        .as_b_o   (as_b),
        .as_sub_o (as_sub),
        .as_s_i   (as_s),
        .as_ov_i  (as_ov)
    );

    always #5 clk = ~clk;

    // The external shared adder/subtractor
    assign as_s  = as_sub ? W'(as_a - as_b) : W'(as_a + as_b);
    assign as_ov = as_sub ? ((as_a[W-1] != as_b[W-1]) && (as_s[W-1] != as_a[W-1]))
                          : ((as_a[W-1] == as_b[W-1]) && (as_s[W-1] != as_a[W-1]));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: 0 idle, 1 operation on the unit, 2 response cycle
    int             m_phase, m_p, m_g, m_cnt;
    logic [N-1:0]   m_gnt, m_done;
    logic [W-1:0]   m_rs, m_asa, m_asb;
    logic           m_rov, m_assub;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int half, sx, sy, r;
        logic ov;
        half = 1 << (W - 1);
        sx   = (int'(x) >= half) ? int'(x) - 2 * half : int'(x);
        sy   = (int'(y) >= half) ? int'(y) - 2 * half : int'(y);
        r    = s ? sx - sy : sx + sy;
        ov   = (r < -half) || (r >= half);
        return {ov, W'(r)};
    endfunction

    task automatic step();
        logic           r_ap = rst_n;
        logic [N-1:0]   q_ap = bus.req;
        logic [N-1:0]   s_ap = bus.sub;
        logic [N*W-1:0] a_ap = bus.a;
        logic [N*W-1:0] b_ap = bus.b;
        logic           c_ap = ov_clr;
        logic [W:0]     res;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (!r_ap) begin
            m_phase = 0; m_p = 0; m_g = 0; m_cnt = 0;
            m_gnt = '0; m_done = '0; m_rs = '0; m_rov = 1'b0;
            m_asa = '0; m_asb = '0; m_assub = 1'b0;
        end else begin
            m_done = '0;
            case (m_phase)
                0: if (q_ap != '0) begin
                    for (int k = 0; k < N; k++) begin
                        if (q_ap[(m_p + k) % N]) begin
                            m_g = (m_p + k) % N;
                            break;
                        end
                    end
                    m_gnt = '0;
                    m_gnt[m_g] = 1'b1;
                    m_asa = a_ap[m_g*W +: W];
                    m_asb = b_ap[m_g*W +: W];
                    m_assub = s_ap[m_g];
                    m_phase = 1;
                end
                1: begin
                    res = ref_op(m_asa, m_asb, m_assub);
                    m_rs = res[W-1:0];
                    m_rov = res[W];
                    if (m_rov && m_cnt < 255) m_cnt++;
                    m_done = m_gnt;
                    m_asa = '0; m_asb = '0; m_assub = 1'b0;
                    m_phase = 2;
                end
                default: begin
                    m_p = (m_g + 1) % N;
                    m_gnt = '0;
                    m_phase = 0;
                end
            endcase
            if (c_ap) m_cnt = 0;
        end
        check_eq("gnt", 32'(bus.gnt), 32'(m_gnt));
        check_eq("done", 32'(bus.done), 32'(m_done));
        check_eq("busy", 32'(busy), 32'(m_phase != 0));
        check_eq("rsp_s", 32'(bus.rsp_s), 32'(m_rs));
        check_eq("rsp_ov", 32'(bus.rsp_ov), 32'(m_rov));
        check_eq("ov_cnt", 32'(ov_cnt), 32'(m_cnt));
        check_eq("as_a", 32'(as_a), 32'(m_asa));
        check_eq("as_b", 32'(as_b), 32'(m_asb));
        check_eq("as_sub", 32'(as_sub), 32'(m_assub));
        // Requesters drop req in the cycle their done is high
        bus.req = bus.req & ~bus.done;
    endtask

    task automatic run_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, input logic clr_in_exec,
                          output logic [W-1:0] rs, output logic rov);
        logic got = 1'b0;
        rs = '0;
        rov = 1'b0;
        bus.a[i*W +: W] = x;
        bus.b[i*W +: W] = y;
        bus.sub[i] = s;
        bus.req[i] = 1'b1;
        for (int t = 0; t < 12 && !got; t++) begin
            step();
            ov_clr = clr_in_exec && bus.gnt[i] && !bus.done[i];
            if (bus.done[i]) begin
                got = 1'b1;
                rs = bus.rsp_s;
                rov = bus.rsp_ov;
            end
        end
        check_eq("op_done_seen", 32'(got), 32'd1);
        ov_clr = 1'b0;
        step();
    endtask

    initial begin
        logic [W-1:0] rs;
        logic         rov;
        logic [N-1:0] prev_gnt, raise;
        int           ngr, last_done;
        logic         w_seen;

        rst_n = 1'b0;
        ov_clr = 1'b0;
        bus.req = '0;
        bus.sub = '0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check_eq("rst_gnt", 32'(bus.gnt), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ov_cnt", 32'(ov_cnt), 32'd0);

        // Fairness: all requesting, each re-raises the cycle after its done
        bus.req = '1;
        prev_gnt = '0;
        raise = '0;
        ngr = 0;
        last_done = -1;
        for (int t = 0; t < 24 && ngr < 5; t++) begin
            step();
            if (bus.gnt != '0 && prev_gnt == '0) begin
                check_eq("rr_order", 32'(bus.gnt), 32'(1 << (ngr % N)));
                ngr++;
            end
            prev_gnt = bus.gnt;
            if (bus.done != '0) begin
                if (last_done >= 0) check_eq("done_spacing", 32'(cyc - last_done), 32'd3);
                last_done = cyc;
            end
            bus.req = bus.req | raise;
            raise = bus.done;
        end
        check_eq("rr_count", 32'(ngr), 32'd5);
        bus.req = '0;
        repeat (3) step();

        // Single operation on requester 2
        run_op(2, 4'd3, 4'd2, 1'b0, 1'b0, rs, rov);
        check_eq("single_s", 32'(rs), 32'd5);
        check_eq("single_ov", 32'(rov), 32'd0);
        check_eq("single_idle", 32'(busy), 32'd0);

        // Overflow and subtract
        run_op(0, 4'd7, 4'd1, 1'b0, 1'b0, rs, rov);
        check_eq("add_ov_s", 32'(rs), 32'h8);
        check_eq("add_ov_f", 32'(rov), 32'd1);
        check_eq("add_ov_cnt", 32'(ov_cnt), 32'd1);
        run_op(0, 4'h8, 4'h1, 1'b1, 1'b0, rs, rov);
        check_eq("sub_ov_s", 32'(rs), 32'h7);
        check_eq("sub_ov_f", 32'(rov), 32'd1);
        check_eq("sub_ov_cnt", 32'(ov_cnt), 32'd2);
        run_op(0, 4'd5, 4'd3, 1'b1, 1'b0, rs, rov);
        check_eq("sub_s", 32'(rs), 32'h2);
        check_eq("sub_f", 32'(rov), 32'd0);
        check_eq("sub_cnt", 32'(ov_cnt), 32'd2);

        // Saturation, then clear colliding with an overflowing capture
        for (int k = 0; k < 256; k++) run_op(k % N, 4'd7, 4'd1, 1'b0, 1'b0, rs, rov);
        check_eq("ov_cnt_sat", 32'(ov_cnt), 32'd255);
        run_op(1, 4'd7, 4'd1, 1'b0, 1'b1, rs, rov);
        check_eq("ov_clr_wins", 32'(ov_cnt), 32'd0);

        // Reset during EXEC
        bus.a[3*W +: W] = 4'd6;
        bus.b[3*W +: W] = 4'd1;
        bus.sub[3] = 1'b0;
        bus.req[3] = 1'b1;
        step();
        check_eq("pre_rst_gnt", 32'(bus.gnt), 32'h8);
        rst_n = 1'b0;
        #1;
        check_eq("async_gnt", 32'(bus.gnt), 32'd0);
        check_eq("async_busy", 32'(busy), 32'd0);
        check_eq("async_rsp_s", 32'(bus.rsp_s), 32'd0);
        check_eq("async_rsp_ov", 32'(bus.rsp_ov), 32'd0);
        check_eq("async_as_a", 32'(as_a), 32'd0);
        step();
        rst_n = 1'b1;
        bus.req = '1;
        step();
        check_eq("post_rst_first", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        repeat (3) step();

        // Withdrawn request: requester 1 pulses req for one cycle while busy
        bus.req[0] = 1'b1;
        step();
        bus.req[1] = 1'b1;
        w_seen = 1'b0;
        for (int t = 0; t < 5; t++) begin
            step();
            bus.req[1] = 1'b0;
            w_seen = w_seen | bus.gnt[1] | bus.done[1];
        end
        check_eq("withdraw_no_serve", 32'(w_seen), 32'd0);

        // Randomized traffic
        for (int t = 0; t < 3000; t++) begin
            step();
            bus.a = (N*W)'($urandom);
            bus.b = (N*W)'($urandom);
            bus.sub = N'($urandom);
            ov_clr = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) begin
                    if ($urandom_range(0, 7) == 0) bus.req[i] = 1'b0;
                end else if (!bus.done[i] && $urandom_range(0, 2) == 0) begin
                    bus.req[i] = 1'b1;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
